mcb_port_responder: RTL
=======================

Name: mcb_port_responder

Overview:
- Cycle-accurate behavioural responder for one Spartan-6 MCB user port (p0): command FIFO, write-data FIFO and read-data FIFO, backed by internal block RAM.
- It is the far end of the lpddr port driven by the RAM controller.
- Substitutes for the lpddr core in simulation and in FPGA builds without external SDRAM.
- It exercises the same cmd/wr/rd handshakes, including latency, full/empty back-pressure and error flags.

Parameters:
- DEPTH_LOG2, 17, log2 of backing store size in 32-bit words.
- CMD_DEPTH, 4, command FIFO entries.
- DATA_DEPTH, 64, write and read data FIFO entries each.
- RD_LATENCY, 8, cycles from read command start to first word pushed into read FIFO (minimum 1).
- CALIB_CYCLES, 16, cycles after reset before calib_done rises.

Ports:
- clk  in  1  single clock for cmd, wr and rd sides.
- reset  in  1  synchronous, active-high.
- calib_done  out  1  port usable.
- cmd_en  in  1  push command.
- cmd_instr  in  3  000 wr, 001 rd, 010 wr+AP, 011 rd+AP, 100 refresh.
- cmd_bl  in  6  burst length minus 1.
- cmd_byte_addr  in  30  byte address.
- cmd_empty  out  1  command FIFO empty.
- cmd_full  out  1  command FIFO full.
- wr_en  in  1  push write word.
- wr_mask  in  4  byte mask, 1 = don't write.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO full.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy.
- wr_underrun  out  1  engine starved this cycle.
- wr_error  out  1  sticky error flag.
- rd_en  in  1  pop read word.
- rd_data  out  32  head word of read FIFO.
- rd_full  out  1  read FIFO full.
- rd_empty  out  1  read FIFO empty.
- rd_count  out  7  read FIFO occupancy.
- rd_overflow  out  1  sticky overflow flag.
- rd_error  out  1  sticky error flag.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: all FIFOs emptied; calib_done=0; cmd_empty=wr_empty=rd_empty=1; wr_count=rd_count=0; all other status outputs 0; rd_data=0.
- Backing store is not cleared by reset.
- Reset mid-burst: aborts the burst; words already written stay written.
- Calibration: counter runs CALIB_CYCLES after reset release, then calib_done=1 until the next reset.
- While calib_done=0, cmd_full=1 and cmd_en is ignored.
- FIFOs: cmd_en while cmd_full drops the command.
- wr_en while wr_full drops the word and sets wr_error (sticky until reset).
- Push and pop in the same cycle are legal; occupancy is unchanged.
- Read FIFO is first-word-fall-through: rd_data is valid whenever rd_empty=0.
- rd_en with rd_empty=1 is a no-op.
- Addressing: word address = cmd_byte_addr[DEPTH_LOG2+1:2]; byte_addr[1:0] ignored.
- Burst word k uses (base+k) mod 2^DEPTH_LOG2 (wraps).
- If cmd_byte_addr[29:DEPTH_LOG2+2] != 0 the command is out of range: reads return 32'hffffffff per word, writes are consumed and discarded.
- Engine FSM states: IDLE, RDLAT, RDXFER, WRXFER.
- IDLE: when the command FIFO is non-empty, pop one command and load remaining = cmd_bl+1.
  - rd/rd+AP → RDLAT, counter = RD_LATENCY-1.
  - wr/wr+AP → WRXFER.
  - refresh or undefined instr → consumed, stay IDLE (one cycle).
- RDLAT: decrement; at 0 → RDXFER.
- RDXFER: push one word per cycle into the read FIFO, remaining--; at last word → IDLE.
  - If the read FIFO is full on a push cycle, the word is lost, rd_overflow=1 and rd_error=1 (sticky), and the burst still advances.
- WRXFER: each cycle with the write FIFO non-empty, pop one word, write memory, remaining--; at last word → IDLE.
  - If the write FIFO is empty, stall; wr_underrun=1 for that cycle only.
- Commands execute strictly in order; a read issued after a write returns the written data.
- Single-word read latency from cmd_en to rd_empty falling: 1 (FIFO) + 1 (IDLE pop) + RD_LATENCY cycles = 10 at defaults.

Optional Feature:
- Macro MCB_PORT_RESPONDER_BYTE_MASK_EN.
- Defined: wr_mask is stored with each write word; masked bytes are left unchanged in memory (byte-enable RAM).
- Undefined: wr_mask is ignored and full 32-bit words are always written; the write FIFO is 32 bits wide.

Decomposition:
- Package mcb_resp_pkg holds:
  - instr encodings: INSTR_WR=3'b000, INSTR_RD=3'b001, INSTR_WR_AP=3'b010, INSTR_RD_AP=3'b011, INSTR_REF=3'b100;
  - engine state encodings;
  - OOR_DATA=32'hffffffff.
- Sub-module mcb_resp_fifo: parameterised width/depth synchronous FWFT FIFO with full/empty/count outputs.
- It is instantiated three times: cmd (39 bits = instr+bl+addr), wr (32 or 36 bits), rd (32 bits).

Test Plan:
- Reset; count cycles → calib_done rises exactly 16 cycles after reset release; cmd_en before that leaves cmd_empty=1.
- Write cmd addr 30'h100, bl=0, then wr_en data 32'hdeadbeef; read cmd addr 30'h100 → rd_data=32'hdeadbeef with rd_empty falling 10 cycles after the read cmd_en; rd_en pop → rd_empty=1.
- Write cmd bl=3 at word 2^17-2 with data 1,2,3,4; read back at word 2^17-2 bl=3 → 1,2,3,4 in order; read word 0 → 3 (wrap).
- Write cmd issued with no data for 5 cycles → wr_underrun high for those 5 cycles, then write completes once data arrives; 65 wr_en pushes into an empty FIFO with the engine idle → wr_full, 65th word dropped, wr_error=1 and held.
- Read cmd with cmd_byte_addr bit 19 set, bl=1 → two words 32'hffffffff; 2 reads of bl=63 with rd_en=0 → rd_overflow=1 and rd_error=1, rd_count=64.
- With MCB_PORT_RESPONDER_BYTE_MASK_EN: memory 32'h11223344, write 32'haabbccdd with mask 4'b0101 → read 32'haa22cc44; without the macro → 32'haabbccdd.

Source files
------------

// File: rtl/mcb_resp_pkg.sv
// mcb_resp_pkg: command encodings, engine states and shared types for the MCB port responder.
package mcb_resp_pkg;
   localparam logic [2:0] INSTR_WR    = 3'b000;
   localparam logic [2:0] INSTR_RD    = 3'b001;
   localparam logic [2:0] INSTR_WR_AP = 3'b010;
   localparam logic [2:0] INSTR_RD_AP = 3'b011;
   localparam logic [2:0] INSTR_REF   = 3'b100;
   localparam logic [31:0] OOR_DATA   = 32'hffffffff;
   typedef enum logic [1:0] {IDLE, RDLAT, RDXFER, WRXFER} state_t;
   typedef struct packed {
      logic [2:0]  instr;
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmd_t;
endpackage

// File: rtl/mcb_port_responder_if.sv
// mcb_port_responder_if: MCB user port p0 cmd/wr/rd signals; master is the controller, slave the responder.
interface mcb_port_responder_if;
   logic        calib_done;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic        cmd_empty, cmd_full;
   logic        wr_en;
   logic [3:0]  wr_mask;
   logic [31:0] wr_data;
   logic        wr_full, wr_empty, wr_underrun, wr_error;
   logic [6:0]  wr_count;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_full, rd_empty, rd_overflow, rd_error;
   logic [6:0]  rd_count;
   modport master (
      input  calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
             rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
      output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
   );
   modport slave (
      output calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
             rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
      input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
   );
endinterface

// File: rtl/mcb_resp_fifo.sv
// mcb_resp_fifo: synchronous first-word-fall-through FIFO; push when full is dropped, dout reads 0 when empty.
module mcb_resp_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 64,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign dout_o  = empty_o ? '0 : mem_q[rp_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   always_ff @(posedge clk)
      if (do_push) mem_q[wp_q] <= din_i;
   always_ff @(posedge clk)
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
         if (do_pop) rp_q <= rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/mcb_port_responder.sv
// mcb_port_responder: cycle-accurate Spartan-6 MCB p0 responder over internal RAM.
// Define MCB_PORT_RESPONDER_BYTE_MASK_EN to store wr_mask per word and honour it as byte enables.
module mcb_port_responder
   import mcb_resp_pkg::*;
#(
   parameter int DEPTH_LOG2   = 17,
   parameter int CMD_DEPTH    = 4,
   parameter int DATA_DEPTH   = 64,
   parameter int RD_LATENCY   = 8,
   parameter int CALIB_CYCLES = 16
) (
   input logic clk,
   input logic reset,
   mcb_port_responder_if.slave p
);
   localparam int LW  = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
   localparam int CCW = $clog2(CALIB_CYCLES + 1);
   localparam int CMW = $clog2(CMD_DEPTH + 1);
   localparam int DW  = $clog2(DATA_DEPTH + 1);
`ifdef MCB_PORT_RESPONDER_BYTE_MASK_EN
   localparam int WW = 36;
`else
   localparam int WW = 32;
`endif
   state_t                state_q;
   logic [6:0]            rem_q;
   logic [LW-1:0]         lat_q;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic [CCW-1:0]        cal_q;
   logic                  oor_q, calib_q, wr_err_q, rd_ovf_q;
   cmd_t                  cmd_h;
   logic                  cmd_empty, cmd_ff;
   logic [CMW-1:0]        unused_cmd_cnt;
   logic [WW-1:0]         wr_h, wr_din;
   logic [DW-1:0]         wr_cnt, rd_cnt;
   logic [31:0]           rdata;
   logic [3:0]            wmask;
   logic                  wr_go, adv, is_rd, is_wr, unused_ok;
`ifdef MCB_PORT_RESPONDER_BYTE_MASK_EN
   assign wr_din    = {p.wr_mask, p.wr_data};
   assign wmask     = wr_h[35:32];
   assign unused_ok = ^cmd_h.addr[1:0];
`else
   assign wr_din    = p.wr_data;
   assign wmask     = 4'h0;
   assign unused_ok = ^{cmd_h.addr[1:0], p.wr_mask};
`endif
   mcb_resp_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd (
      .clk(clk), .reset(reset), .push_i(p.cmd_en && calib_q),
      .din_i({p.cmd_instr, p.cmd_bl, p.cmd_byte_addr}), .pop_i(state_q == IDLE),
      .dout_o(cmd_h), .full_o(cmd_ff), .empty_o(cmd_empty), .count_o(unused_cmd_cnt)
   );
   mcb_resp_fifo #(.W(WW), .DEPTH(DATA_DEPTH)) u_wr (
      .clk(clk), .reset(reset), .push_i(p.wr_en), .din_i(wr_din), .pop_i(state_q == WRXFER),
      .dout_o(wr_h), .full_o(p.wr_full), .empty_o(p.wr_empty), .count_o(wr_cnt)
   );
   mcb_resp_fifo #(.W(32), .DEPTH(DATA_DEPTH)) u_rd (
      .clk(clk), .reset(reset), .push_i(state_q == RDXFER), .din_i(oor_q ? OOR_DATA : rdata),
      .pop_i(p.rd_en), .dout_o(p.rd_data), .full_o(p.rd_full), .empty_o(p.rd_empty), .count_o(rd_cnt)
   );
   assign p.calib_done  = calib_q;
   assign p.cmd_full    = !calib_q || cmd_ff;
   assign p.cmd_empty   = cmd_empty;
   assign p.wr_count    = 7'(wr_cnt);
   assign p.rd_count    = 7'(rd_cnt);
   assign p.wr_underrun = state_q == WRXFER && p.wr_empty;
   assign p.wr_error    = wr_err_q;
   assign p.rd_overflow = rd_ovf_q;
   assign p.rd_error    = rd_ovf_q;
   assign is_rd  = cmd_h.instr == INSTR_RD || cmd_h.instr == INSTR_RD_AP;
   assign is_wr  = cmd_h.instr == INSTR_WR || cmd_h.instr == INSTR_WR_AP;
   assign adv    = state_q == RDXFER || (state_q == WRXFER && !p.wr_empty);
   assign wr_go  = state_q == WRXFER && !p.wr_empty && !oor_q && !reset;
   // addr_d feeds the RAM read port so the word for addr_q is already registered when RDXFER pushes it
   assign addr_d = state_q == IDLE ? cmd_h.addr[DEPTH_LOG2+1:2] : adv ? addr_q + 1'b1 : addr_q;
   for (genvar g = 0; g < 4; g++) begin : bank
      logic [7:0] mem_q [2**DEPTH_LOG2];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
         if (wr_go && !wmask[g]) mem_q[addr_q] <= wr_h[8*g +: 8];
         rd_q <= mem_q[addr_d];
      end
   end
   assign rdata = {bank[3].rd_q, bank[2].rd_q, bank[1].rd_q, bank[0].rd_q};
   always_ff @(posedge clk)
      if (reset) begin
         cal_q   <= '0;
         calib_q <= 1'b0;
      end else if (!calib_q) begin
         cal_q   <= cal_q + 1'b1;
         calib_q <= cal_q == CCW'(CALIB_CYCLES - 1);
      end
   always_ff @(posedge clk)
      if (reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         lat_q    <= '0;
         addr_q   <= '0;
         oor_q    <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ovf_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         if (p.wr_en && p.wr_full) wr_err_q <= 1'b1;
         case (state_q)
            IDLE: if (!cmd_empty) begin
               rem_q   <= 7'(cmd_h.bl) + 7'd1;
               lat_q   <= LW'(RD_LATENCY - 1);
               oor_q   <= |cmd_h.addr[29:DEPTH_LOG2+2];
               state_q <= is_rd ? RDLAT : is_wr ? WRXFER : IDLE;
            end
            RDLAT: begin
               lat_q <= lat_q - 1'b1;
               if (lat_q == '0) state_q <= RDXFER;
            end
            RDXFER: begin
               rem_q <= rem_q - 1'b1;
               if (p.rd_full) rd_ovf_q <= 1'b1;
               if (rem_q == 7'd1) state_q <= IDLE;
            end
            WRXFER: if (!p.wr_empty) begin
               rem_q <= rem_q - 1'b1;
               if (rem_q == 7'd1) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
endmodule
